// File: rtl/gps_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | gps_pkg: shared constants, types and helpers for GPS blocks     |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package gps_pkg;

  localparam int CA_CODE_LEN = 1023;

  // Signed width that holds +/-(len*spc) without overflow.
  function automatic int corr_width(input int len, input int spc);
    return $clog2(len * spc + 1) + 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    INTEGRATE = 1'b1
  } corr_state_t;

endpackage : gps_pkg
`default_nettype wire

// File: rtl/corr_hold_reg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | corr_hold_reg: valid/ready result holding register, overrun     |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module corr_hold_reg #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  input  logic         i_clear,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_overrun;
  logic         w_accept;

  // A load is accepted when the slot is empty or being drained this very cycle.
  assign w_accept = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_clear) begin
        r_overrun <= 1'b0;
      end
      if (i_load) begin
        if (w_accept) begin
          r_data  <= i_data;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule : corr_hold_reg
`default_nettype wire

// File: rtl/ca_correlator.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ca_correlator: 1-bit C/A integrate-and-dump correlator          |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module ca_correlator
  import gps_pkg::*;
#(
  parameter int CODE_LEN         = CA_CODE_LEN,
  parameter int SAMPLES_PER_CHIP = 1,
  parameter int ACC_W            = corr_width(CODE_LEN, SAMPLES_PER_CHIP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sample,
  input  logic             chip,
  input  logic             epoch,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun,
  input  logic             clear_overrun,
  output logic             sync_err
);

  localparam int c_MAX   = CODE_LEN * SAMPLES_PER_CHIP;
  localparam int c_CNT_W = $clog2(c_MAX + 1);

  corr_state_t        r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sync_err;

  logic [ACC_W-1:0]   w_d;
  logic               w_dump;

  assign w_d    = (sample == chip) ? ACC_W'(1) : {ACC_W{1'b1}};
  assign w_dump = en && epoch && (r_state == INTEGRATE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sync_err <= 1'b0;
    end else begin
      // Clear first so a same-cycle sync loss below takes priority.
      if (clear_overrun) begin
        r_sync_err <= 1'b0;
      end
      if (en) begin
        case (r_state)
          IDLE: begin
            if (epoch) begin
              r_acc   <= w_d;
              r_cnt   <= c_CNT_W'(1);
              r_state <= INTEGRATE;
            end
          end
          INTEGRATE: begin
            if (epoch) begin
              r_acc <= w_d;
              r_cnt <= c_CNT_W'(1);
            end else if (r_cnt == c_CNT_W'(c_MAX)) begin
              r_sync_err <= 1'b1;
              r_acc      <= '0;
              r_cnt      <= '0;
              r_state    <= IDLE;
            end else begin
              r_acc <= r_acc + w_d;
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  corr_hold_reg #(
    .W (ACC_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_dump),
    .i_data    (r_acc),
    .i_ready   (result_ready),
    .i_clear   (clear_overrun),
    .o_data    (result),
    .o_valid   (result_valid),
    .o_overrun (overrun)
  );

  assign sync_err = r_sync_err;

endmodule : ca_correlator
`default_nettype wire

// File: tb/tb_ca_correlator.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_ca_correlator: directed self-checking bench for ca_correlator|
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_ca_correlator;

  localparam int ACC_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sample;
  logic             chip;
  logic             epoch;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             overrun;
  logic             clear_overrun;
  logic             sync_err;

  int errors = 0;
  int checks = 0;
  bit prn [0:1022];

  always #5 clk = ~clk;

  ca_correlator #(
    .CODE_LEN         (1023),
    .SAMPLES_PER_CHIP (1),
    .ACC_W            (ACC_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .sample        (sample),
    .chip          (chip),
    .epoch         (epoch),
    .result        (result),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .sync_err      (sync_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then sample 1 ns later.
  task automatic step(input bit e, input bit s, input bit c, input bit ep);
    en = e; sample = s; chip = c; epoch = ep;
    @(posedge clk);
    #1;
    en = 1'b0; epoch = 1'b0;
  endtask

  function automatic bit samp(input int mode, input int i);
    case (mode)
      0:       return prn[i];
      1:       return ~prn[i];
      default: return 1'b0;
    endcase
  endfunction

  // Samples start..1022 of a period; epoch accompanies index 0.
  task automatic period(input int mode, input int start);
    for (int i = start; i < 1023; i++) step(1'b1, samp(mode, i), prn[i], i == 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  function automatic int sres();
    return int'($signed(result));
  endfunction

  initial begin
    logic [9:0] g1, g2;
    g1 = '1; g2 = '1;
    for (int i = 0; i < 1023; i++) begin
      prn[i] = g1[9] ^ g2[1] ^ g2[5];
      g1 = {g1[8:0], g1[2] ^ g1[9]};
      g2 = {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
    end

    en = 0; sample = 0; chip = 0; epoch = 0;
    result_ready = 0; clear_overrun = 0; rst = 1;
    do_reset();
    check("reset_result", sres(), 0);
    check("reset_valid", int'(result_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_sync_err", int'(sync_err), 0);

    // Full agreement, then disagreement, then constant-zero input.
    period(0, 0);
    check("agree_no_valid_before_epoch", int'(result_valid), 0);
    step(1'b1, samp(1, 0), prn[0], 1'b1);
    check("agree_valid", int'(result_valid), 1);
    check("agree_result", sres(), 1023);
    result_ready = 1;
    period(1, 1);
    check("drain_valid", int'(result_valid), 0);
    check("drain_result_kept", sres(), 1023);
    step(1'b1, samp(2, 0), prn[0], 1'b1);
    check("disagree_result", sres(), -1023);
    period(2, 1);
    step(1'b1, samp(0, 0), prn[0], 1'b1);
    check("const_result", sres(), -1);
    check("const_valid", int'(result_valid), 1);
    result_ready = 0;

    // Overrun: unread -1 held while an agreement dump arrives.
    period(0, 1);
    step(1'b1, samp(0, 0), prn[0], 1'b1);
    check("overrun_set", int'(overrun), 1);
    check("overrun_result_kept", sres(), -1);
    check("overrun_valid", int'(result_valid), 1);
    clear_overrun = 1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    clear_overrun = 0;
    check("overrun_cleared", int'(overrun), 0);
    for (int i = 1; i < 5; i++) step(1'b1, samp(0, i), prn[i], 1'b0);
    result_ready = 1;
    step(1'b1, samp(0, 0), prn[0], 1'b1);
    result_ready = 0;
    check("early_dump_result", sres(), 5);
    check("early_dump_valid", int'(result_valid), 1);
    check("early_dump_no_overrun", int'(overrun), 0);

    // Sync loss from a clean start.
    do_reset();
    period(0, 0);
    check("sync_ok_at_max", int'(sync_err), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sync_err_set", int'(sync_err), 1);
    check("sync_no_valid", int'(result_valid), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    period(0, 0);
    check("sync_idle_ignored", int'(result_valid), 0);
    step(1'b1, samp(0, 0), prn[0], 1'b1);
    check("sync_restart_result", sres(), 1023);
    check("sync_err_sticky", int'(sync_err), 1);
    clear_overrun = 1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    clear_overrun = 0;
    check("sync_err_cleared", int'(sync_err), 0);

    // Reset mid-period drops the partial sum and held result.
    for (int i = 1; i < 500; i++) step(1'b1, samp(1, i), prn[i], 1'b0);
    do_reset();
    check("midrst_result", sres(), 0);
    check("midrst_valid", int'(result_valid), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_sync_err", int'(sync_err), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    period(0, 0);
    step(1'b1, samp(0, 0), prn[0], 1'b1);
    check("midrst_fresh_result", sres(), 1023);
    check("midrst_fresh_valid", int'(result_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ca_correlator
`default_nettype wire

// File: doc/ca_correlator.md
# ca_correlator

Integrate-and-dump correlator for the 1-bit GPS front-end path. It consumes the XOR-mixer output (`sample`) together with the local C/A chip and epoch pulse from the C/A code generator. Over one full code period it accumulates a signed agreement count: +1 when sample equals chip, −1 otherwise. At each epoch it dumps the count into a held output register, which is read by the SPI core through a valid/ready handshake.

## Interface
- `CODE_LEN`, 1023, chips per C/A period
- `SAMPLES_PER_CHIP`, 1, `en` strobes per chip
- `ACC_W`, 11, signed accumulator/result width; must hold ±CODE_LEN·SAMPLES_PER_CHIP
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `en`  in  1  sample strobe; all other inputs qualified by it except `result_ready`, `clear_overrun`
- `sample`  in  1  mixed 1-bit signal
- `chip`  in  1  local C/A chip aligned with `sample`
- `epoch`  in  1  high with `en` on the first sample of a code period
- `result`  out  ACC_W  signed correlation of last completed period
- `result_valid`  out  1  `result` holds an unread value
- `result_ready`  in  1  consumer accepts `result` when high with `result_valid`
- `overrun`  out  1  sticky; a dump was discarded because `result` was unread
- `clear_overrun`  in  1  clears `overrun`
- `sync_err`  out  1  sticky; period exceeded CODE_LEN·SAMPLES_PER_CHIP samples without an epoch; cleared by `clear_overrun`

## Operation
- Define `MAX = CODE_LEN·SAMPLES_PER_CHIP` and `d = (sample == chip) ? +1 : −1`.
- State IDLE (reset state):
  - `en && epoch` sets acc = d and cnt = 1, then goes to INTEGRATE.
  - All other inputs are ignored.
- State INTEGRATE, `en && !epoch`:
  - If cnt < MAX: acc += d, cnt += 1.
  - If cnt == MAX: set `sync_err`, clear acc and cnt, go to IDLE. No dump occurs.
- State INTEGRATE, `en && epoch` (dump):
  - Transfer acc into the output register (rules below).
  - Then set acc = d, cnt = 1, and stay in INTEGRATE.
  - An early epoch (cnt < MAX) still dumps the partial sum.
- Output register rules on a dump:
  - If `result_valid` is 0, or `result_ready` is 1 in the same cycle: load `result`, and `result_valid` becomes 1.
  - Otherwise keep the old `result`, discard the new value, and set `overrun`.
- Without a dump, `result_valid && result_ready` clears `result_valid`. `result` keeps its value.
- `epoch` without `en` is ignored. `en` low means acc and cnt are unchanged.
- Arithmetic is two's complement at ACC_W bits. By parameter constraint, no overflow is possible.
- `clear_overrun` clears both sticky flags. If a flag-setting event occurs in the same cycle, set wins.

## Timing
- Reset values: `result` = 0, `result_valid` = 0, `overrun` = 0, `sync_err` = 0. Internal state: IDLE, acc = 0, cnt = 0.
- Reset mid-integration drops the partial sum. The next `en && epoch` starts fresh.
- Dump latency: `en && epoch` at edge N puts `result`/`result_valid` at N+1.
- Handshake transfer occurs at the edge where valid && ready. Valid deasserts at the next cycle unless a simultaneous dump reloads it.
- `result` is stable while `result_valid` is high.
- Throughput: one `en` per clock is supported. No stall toward the code generator.

## Structure
- Shared package `gps_pkg`:
  - Constant `CA_CODE_LEN` = 1023.
  - Function `corr_width(len, spc)` returning ⌈log2(len·spc+1)⌉+1.
  - Correlator state enum {IDLE, INTEGRATE}.
- One sub-module is natural: `corr_hold_reg`. It is the valid/ready output holding register with overrun detection, reusable for further correlator channels.

## Test plan
- **Full agreement:** `sample` = `chip` for 1023 `en` cycles, epochs on samples 0 and 1023 → `result` = +1023, valid one cycle after second epoch.
- **Full disagreement:** `sample` = ~`chip` → `result` = −1023.
- **Constant input:** `sample` = 0 against PRN 1 code (512 ones/511 zeros) → `result` = −1.
- **Overrun:** `result_ready` held 0 across two dumps → first value retained, `overrun` = 1. Then pulse `clear_overrun` → `overrun` = 0. A dump with `result_ready` = 1 in the same cycle → new value loaded, no overrun.
- **Sync loss:** 1024 `en` without second epoch → `sync_err` = 1 on 1024th, no `result_valid`. Next epoch restarts integration.
- **Reset mid-period:** `rst` low for 1 cycle at sample 500 → all outputs 0. Next epoch starts a fresh period; a full-agreement period then yields +1023.
